// File: rtl/dmem_port_ctrl.sv
// dmem_port_ctrl: owns the single data-memory port. It arbitrates store-buffer
// drains (priority) against LSU loads, holds the selected request on the dmem
// bus until dmem_resp, returns load data with its tag, and publishes mem_state
// for the store buffer's push/pop decision.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   sb_addr/sb_wmask/sb_wdata     store-buffer drain request (wmask != 0)
//   ld_valid/ld_addr/ld_rmask/
//   ld_tag, ld_ready              LSU load request handshake
//   ld_resp_valid/rdata/tag       one-cycle load return
//   mem_state                     0 idle, 1 load, 2 store (registered)
//   dmem_addr/rmask/wmask/wdata   registered memory request
//   dmem_rdata, dmem_resp         memory return data and completion pulse
//   err_timeout                   one-cycle pulse when an access waits too long
module dmem_port_ctrl #(
    parameter int unsigned TAG_WIDTH      = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          sb_addr,
    input  logic [3:0]           sb_wmask,
    input  logic [31:0]          sb_wdata,
    input  logic                 ld_valid,
    input  logic [31:0]          ld_addr,
    input  logic [3:0]           ld_rmask,
    input  logic [TAG_WIDTH-1:0] ld_tag,
    output logic                 ld_ready,
    output logic                 ld_resp_valid,
    output logic [31:0]          ld_resp_rdata,
    output logic [TAG_WIDTH-1:0] ld_resp_tag,
    output logic [1:0]           mem_state,
    output logic [31:0]          dmem_addr,
    output logic [3:0]           dmem_rmask,
    output logic [3:0]           dmem_wmask,
    output logic [31:0]          dmem_wdata,
    input  logic [31:0]          dmem_rdata,
    input  logic                 dmem_resp,
    output logic                 err_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [TAG_WIDTH-1:0] tag_q, tag_nx;
    logic [CNT_W-1:0]     cnt_q, cnt_nx;
    logic [31:0]          addr_nx, wdata_nx, resp_rdata_nx;
    logic [3:0]           rmask_nx, wmask_nx;
    logic [TAG_WIDTH-1:0] resp_tag_nx;
    logic                 resp_valid_nx, err_nx;

    // mem_state is the state register itself, so it never depends on inputs
    assign mem_state = state;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            tag_q         <= '0;
            cnt_q         <= '0;
            dmem_addr     <= '0;
            dmem_rmask    <= '0;
            dmem_wmask    <= '0;
            dmem_wdata    <= '0;
            ld_resp_valid <= 1'b0;
            ld_resp_rdata <= '0;
            ld_resp_tag   <= '0;
            err_timeout   <= 1'b0;
        end else begin
            state         <= state_nx;
            tag_q         <= tag_nx;
            cnt_q         <= cnt_nx;
            dmem_addr     <= addr_nx;
            dmem_rmask    <= rmask_nx;
            dmem_wmask    <= wmask_nx;
            dmem_wdata    <= wdata_nx;
            ld_resp_valid <= resp_valid_nx;
            ld_resp_rdata <= resp_rdata_nx;
            ld_resp_tag   <= resp_tag_nx;
            err_timeout   <= err_nx;
        end
    end

    // Next-state, request capture, completion and timeout logic
    always_comb begin
        state_nx      = state;
        tag_nx        = tag_q;
        cnt_nx        = cnt_q;
        addr_nx       = dmem_addr;
        rmask_nx      = dmem_rmask;
        wmask_nx      = dmem_wmask;
        wdata_nx      = dmem_wdata;
        resp_valid_nx = 1'b0;
        resp_rdata_nx = ld_resp_rdata;
        resp_tag_nx   = ld_resp_tag;
        err_nx        = 1'b0;
        ld_ready      = 1'b0;

        case (state)
            IDLE: begin
                cnt_nx   = '0;
                ld_ready = (sb_wmask == 4'd0);
                if (sb_wmask != 4'd0) begin
                    // store drain wins; a simultaneous load stays held by the LSU
                    state_nx = STORE;
                    addr_nx  = sb_addr & WORD_MASK;
                    wmask_nx = sb_wmask;
                    rmask_nx = 4'd0;
                    wdata_nx = sb_wdata;
                end else if (ld_valid) begin
                    state_nx = LOAD;
                    addr_nx  = ld_addr & WORD_MASK;
                    rmask_nx = ld_rmask;
                    wmask_nx = 4'd0;
                    tag_nx   = ld_tag;
                end
            end
            LOAD, STORE: begin
                if (dmem_resp) begin
                    state_nx = IDLE;
                    rmask_nx = 4'd0;
                    wmask_nx = 4'd0;
                    cnt_nx   = '0;
                    if (state == LOAD) begin
                        resp_valid_nx = 1'b1;
                        resp_rdata_nx = dmem_rdata;
                        resp_tag_nx   = tag_q;
                    end
                end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                    // saturating wait counter; the access itself keeps going
                    cnt_nx = cnt_q + CNT_W'(1);
                    err_nx = (cnt_nx == CNT_W'(TIMEOUT_CYCLES));
                end
            end
            default: begin
                state_nx = IDLE;
                rmask_nx = 4'd0;
                wmask_nx = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
module tb_dmem_port_ctrl;

    localparam int unsigned TW = 5;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   sb_addr;
    logic [3:0]    sb_wmask;
    logic [31:0]   sb_wdata;
    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic [3:0]    ld_rmask;
    logic [TW-1:0] ld_tag;
    logic          ld_ready;
    logic          ld_resp_valid;
    logic [31:0]   ld_resp_rdata;
    logic [TW-1:0] ld_resp_tag;
    logic [1:0]    mem_state;
    logic [31:0]   dmem_addr;
    logic [3:0]    dmem_rmask;
    logic [3:0]    dmem_wmask;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_rdata;
    logic          dmem_resp;
    logic          err_timeout;

    dmem_port_ctrl #(.TAG_WIDTH(TW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .sb_addr(sb_addr), .sb_wmask(sb_wmask), .sb_wdata(sb_wdata),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_rmask(ld_rmask), .ld_tag(ld_tag),
        .ld_ready(ld_ready),
        .ld_resp_valid(ld_resp_valid), .ld_resp_rdata(ld_resp_rdata), .ld_resp_tag(ld_resp_tag),
        .mem_state(mem_state),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   rdata;
        logic [TW-1:0] tag;
    } ld_exp_t;

    ld_exp_t     exp_q[$];
    logic [31:0] mem [int unsigned];
    int          total = 0;
    int          bad = 0;
    int          resp_seen = 0;
    int          err_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory contents seen by loads; untouched words have a recognisable pattern
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int unsigned k;
        k = a / 4;
        if (mem.exists(k)) return mem[k];
        return (a - (a % 4)) ^ 32'h5A5A_1234;
    endfunction

    // Monitor: every load return is popped from the scoreboard and compared
    initial begin
        ld_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (ld_resp_valid === 1'b1) begin
                resp_seen++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ld_resp actual tag=%0d rdata=%h required=no response",
                             ld_resp_tag, ld_resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("ld_resp_rdata", ld_resp_rdata, e.rdata);
                    chk("ld_resp_tag", 32'(ld_resp_tag), 32'(e.tag));
                end
            end
            if (err_timeout === 1'b1) err_seen++;
        end
    end

    // Present a load while idle and check it is accepted
    task automatic issue_ld(input logic [31:0] a, input logic [3:0] m, input logic [TW-1:0] tg);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_rmask = m;
        ld_tag   = tg;
        #1;
        chk("ld_ready_idle", 32'(ld_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic issue_st(input logic [31:0] a, input logic [3:0] m, input logic [31:0] wd);
        sb_addr  = a;
        sb_wmask = m;
        sb_wdata = wd;
        #1;
        chk("ld_ready_store_pending", 32'(ld_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        sb_wmask = 4'd0;
    endtask

    // Called at the first negedge after acceptance: check the held request for
    // d+1 cycles, then complete it as memory would
    task automatic serve(input bit is_ld, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] wd, input logic [TW-1:0] tg, input int d);
        logic [31:0] rd;
        logic [31:0] w;
        for (int j = 0; j <= d; j++) begin
            chk("mem_state_busy", 32'(mem_state), is_ld ? 32'd1 : 32'd2);
            chk("dmem_addr", dmem_addr, a - (a % 4));
            chk("dmem_rmask", 32'(dmem_rmask), is_ld ? 32'(m) : 32'd0);
            chk("dmem_wmask", 32'(dmem_wmask), is_ld ? 32'd0 : 32'(m));
            if (!is_ld) chk("dmem_wdata", dmem_wdata, wd);
            chk("ld_ready_busy", 32'(ld_ready), 32'd0);
            if (j < d) @(negedge clk);
        end
        if (is_ld) begin
            rd = mem_rd(a);
            exp_q.push_back('{rd, tg});
            dmem_rdata = rd;
        end else begin
            dmem_rdata = $urandom;
            w = mem_rd(a);
            for (int b = 0; b < 4; b++)
                if (m[b]) w[8*b +: 8] = wd[8*b +: 8];
            mem[a / 4] = w;
        end
        dmem_resp = 1'b1;
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("mem_state_done", 32'(mem_state), 32'd0);
        chk("dmem_rmask_done", 32'(dmem_rmask), 32'd0);
        chk("dmem_wmask_done", 32'(dmem_wmask), 32'd0);
        chk("ld_resp_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int seen;
        logic [31:0] a, a2, wd;
        logic [3:0]  m, m2;
        logic [TW-1:0] tg;
        rst = 1'b1;
        sb_addr = '0; sb_wmask = '0; sb_wdata = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_rmask = '0; ld_tag = '0;
        dmem_rdata = '0; dmem_resp = 1'b0;

        // Reset state
        @(negedge clk);
        #2;
        chk("rst_mem_state", 32'(mem_state), 32'd0);
        chk("rst_rmask", 32'(dmem_rmask), 32'd0);
        chk("rst_wmask", 32'(dmem_wmask), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_resp_valid", 32'(ld_resp_valid), 32'd0);
        chk("rst_resp_rdata", ld_resp_rdata, 32'd0);
        chk("rst_resp_tag", 32'(ld_resp_tag), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(ld_ready), 32'd1);

        // Single load
        mem[32'h1004 / 4] = 32'hDEAD_BEEF;
        issue_ld(32'h0000_1006, 4'b1100, 5'd3);
        serve(1'b1, 32'h0000_1006, 4'b1100, 32'd0, 5'd3, 2);

        // Store drain: no load response may appear
        seen = resp_seen;
        issue_st(32'h0000_2000, 4'b1111, 32'h1234_5678);
        serve(1'b0, 32'h0000_2000, 4'b1111, 32'h1234_5678, '0, 3);
        @(negedge clk);
        chk("store_no_resp", 32'(resp_seen), 32'(seen));

        // Contention: store first, held load issues on the next idle cycle
        sb_addr = 32'h0000_2001; sb_wmask = 4'b0011; sb_wdata = 32'hCAFE_F00D;
        ld_valid = 1'b1; ld_addr = 32'h0000_2003; ld_rmask = 4'b1000; ld_tag = 5'd17;
        #1;
        chk("contention_ld_ready", 32'(ld_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        sb_wmask = 4'd0;
        serve(1'b0, 32'h0000_2001, 4'b0011, 32'hCAFE_F00D, '0, 1);
        issue_ld(32'h0000_2003, 4'b1000, 5'd17);
        serve(1'b1, 32'h0000_2003, 4'b1000, 32'd0, 5'd17, 1);

        // Reset mid-load, then a late response that must be ignored
        seen = resp_seen;
        issue_ld(32'h0000_3008, 4'b0001, 5'd9);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_mem_state", 32'(mem_state), 32'd0);
        chk("midrst_rmask", 32'(dmem_rmask), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dmem_rdata = 32'hBAD0_BAD0;
        dmem_resp = 1'b1;
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("late_resp_state", 32'(mem_state), 32'd0);
        chk("late_resp_rmask", 32'(dmem_rmask), 32'd0);
        chk("late_resp_wmask", 32'(dmem_wmask), 32'd0);
        @(negedge clk);
        chk("late_resp_ignored", 32'(resp_seen), 32'(seen));

        // Timeout: one pulse after 8 waiting cycles, access untouched
        issue_ld(32'h0000_100C, 4'b0110, 5'd21);
        for (int k = 0; k < 12; k++) begin
            chk("timeout_pulse", 32'(err_timeout), (k == 8) ? 32'd1 : 32'd0);
            chk("timeout_rmask", 32'(dmem_rmask), 32'b0110);
            chk("timeout_addr", dmem_addr, 32'h0000_100C);
            @(negedge clk);
        end
        serve(1'b1, 32'h0000_100C, 4'b0110, 32'd0, 5'd21, 0);

        // Randomized traffic over a small address window
        for (int it = 0; it < 40; it++) begin
            a  = 32'h1000 + $urandom_range(0, 63);
            a2 = 32'h1000 + $urandom_range(0, 63);
            m  = 4'($urandom_range(1, 15));
            m2 = 4'($urandom_range(1, 15));
            wd = $urandom;
            tg = TW'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0: begin
                    issue_st(a, m, wd);
                    serve(1'b0, a, m, wd, '0, $urandom_range(0, 5));
                end
                1: begin
                    issue_ld(a, m, tg);
                    serve(1'b1, a, m, 32'd0, tg, $urandom_range(0, 5));
                end
                default: begin
                    sb_addr = a; sb_wmask = m; sb_wdata = wd;
                    ld_valid = 1'b1; ld_addr = a2; ld_rmask = m2; ld_tag = tg;
                    #1;
                    chk("rand_contention_ready", 32'(ld_ready), 32'd0);
                    @(posedge clk);
                    @(negedge clk);
                    sb_wmask = 4'd0;
                    serve(1'b0, a, m, wd, '0, $urandom_range(0, 5));
                    issue_ld(a2, m2, tg);
                    serve(1'b1, a2, m2, 32'd0, tg, $urandom_range(0, 5));
                end
            endcase
            repeat ($urandom_range(0, 2)) begin
                chk("idle_ready", 32'(ld_ready), 32'd1);
                @(negedge clk);
            end
        end

        @(negedge clk);
        chk("err_timeout_count", 32'(err_seen), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_port_ctrl.md
Name: dmem_port_ctrl

Overview:
- Sits directly downstream of the store buffer and beside the load path of the load/store unit.
- Owns the single data-memory port and arbitrates between store-buffer drains and load requests.
- Registers the selected request and holds it on the dmem bus until dmem_resp.
- Returns load data to the LSU and publishes mem_state, which the store buffer uses to decide push vs pop.

Parameters:
- TAG_WIDTH, 5, width of the load tag (ROB/LSQ index) carried through and returned with load data.
- TIMEOUT_CYCLES, 1023, cycles an outstanding access may wait for dmem_resp before err_timeout pulses.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- sb_addr  in  32  store-buffer drain address.
- sb_wmask  in  4  store-buffer byte write mask; nonzero = drain request this cycle.
- sb_wdata  in  32  store-buffer write data.
- ld_valid  in  1  LSU load request.
- ld_addr  in  32  load address.
- ld_rmask  in  4  load byte mask; must be nonzero when ld_valid.
- ld_tag  in  TAG_WIDTH  load tag.
- ld_ready  out  1  load accepted this cycle when ld_valid && ld_ready.
- ld_resp_valid  out  1  one-cycle pulse: load data valid.
- ld_resp_rdata  out  32  raw 32-bit word returned by memory.
- ld_resp_tag  out  TAG_WIDTH  tag of the returned load.
- mem_state  out  2  0 = mem_idle, 1 = mem_load, 2 = mem_store.
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- dmem_rmask  out  4  read mask.
- dmem_wmask  out  4  write mask.
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  memory read data.
- dmem_resp  in  1  memory completion, one-cycle pulse.
- err_timeout  out  1  one-cycle pulse when the timeout counter expires.

Behaviour:
- FSM states: IDLE, LOAD, STORE. mem_state is a direct encoding of the current state and is registered (it is not a function of the current-cycle inputs).
- Reset (async, immediate on rst high):
  - state = IDLE, so mem_state = 0.
  - dmem_rmask = 0 and dmem_wmask = 0; dmem_addr and dmem_wdata = 0.
  - ld_resp_valid = 0, ld_resp_rdata = 0, ld_resp_tag = 0, err_timeout = 0, timeout counter = 0.
  - Reset mid-access abandons the access. Any dmem_resp that arrives after reset is ignored.
- IDLE:
  - sb_wmask != 0 has priority. Latch addr/wmask/wdata, next state = STORE; dmem_wmask is driven from the next cycle.
  - Otherwise, if ld_valid: latch addr/rmask/tag, next state = LOAD; dmem_rmask is driven from the next cycle.
  - ld_ready = (state == IDLE) && (sb_wmask == 0). This is combinational and forced 0 in LOAD and STORE.
- LOAD / STORE:
  - Registered dmem outputs stay constant until dmem_resp.
  - On dmem_resp, the masks clear the next cycle and next state = IDLE. There is no back-to-back issue, so there is a minimum one idle cycle between accesses; the store buffer sees mem_state = 0 for that cycle and may pop.
- Load return: on dmem_resp in LOAD, ld_resp_valid pulses the following cycle with ld_resp_rdata = dmem_rdata captured at dmem_resp and ld_resp_tag = the latched tag.
- Store completion produces no response output.
- Latency: request accepted at cycle N → dmem request visible at N+1. A dmem_resp at cycle M → ld_resp_valid at M+1 and state IDLE at M+1.
- dmem_resp while in IDLE is ignored.
- Masks:
  - rmask and wmask are never both nonzero.
  - dmem_wdata is passed through unmodified.
  - Low address bits are zeroed only on dmem_addr; byte lanes come from the mask.
- Timeout:
  - The counter increments each cycle in LOAD/STORE and clears on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES, err_timeout pulses for one cycle and the counter saturates. The access is not aborted.
- Simultaneous sb_wmask != 0 and ld_valid in IDLE: the store wins, ld_ready = 0, and the load must be held by the LSU.

Test Plan:
- Reset then idle: rst pulsed asynchronously between clock edges → mem_state = 0, all masks 0, ld_ready = 1 immediately after release.
- Single load: ld_valid, addr 0x0000_1006, rmask 4'b1100, tag 5'd3 → next cycle dmem_addr = 0x0000_1004, rmask 4'b1100, mem_state = 1. dmem_resp with rdata 0xDEAD_BEEF 3 cycles later → next cycle ld_resp_valid = 1, rdata 0xDEAD_BEEF, tag 3, mem_state = 0.
- Store drain: sb_wmask 4'b1111, addr 0x2000, wdata 0x1234_5678 → dmem_wmask 4'b1111 held stable until dmem_resp, mem_state = 2, ld_resp_valid never asserted.
- Contention: sb_wmask 4'b0011 and ld_valid the same cycle → ld_ready = 0, store issued first. The load is issued on the first IDLE cycle after the store's dmem_resp, with tag preserved.
- Reset mid-load: rst during LOAD, then a late dmem_resp → no ld_resp_valid, state IDLE, masks 0.
- Timeout: TIMEOUT_CYCLES = 8, no dmem_resp → err_timeout pulses exactly once at cycle 8 of waiting, dmem outputs unchanged. A later dmem_resp completes normally.
